wb_pipe_stage: RTL and testbench
================================

// Module: wb_pipe_stage
// PURPOSE
//  Parametrised MEM->WB pipeline stage: 2-entry elastic buffer (head + skid) with valid/ready
//  handshake, flush, bubble-safe writeback controls and a stall counter. Sits between the data
//  memory stage and the register file; optional half-cycle output mode lets the register file
//  write mid-cycle and be read in the same cycle.
// PARAMETERS
//  DATA_W        32  width of memdata/aludata/wb_data
//  RD_W          5   destination register address width
//  CTRL_W        2   WB control width; bit CTRL_W-1 = RegWrite, bit CTRL_W-2 = MemToReg
//  HALF_CYCLE    0   1: payload outputs update on falling edge of clk_i; 0: on rising edge
// PORTS
//  clk_i         in   1       clock
//  rst_i         in   1       synchronous reset, active-high
//  in_valid_i    in   1       upstream beat valid
//  in_ready_o    out  1       stage can accept a beat (registered)
//  flush_i       in   1       discard all held beats (synchronous)
//  ctrl_i        in   CTRL_W  WB control bits
//  memdata_i     in   DATA_W  memory read data
//  aludata_i     in   DATA_W  ALU result
//  rdaddr_i      in   RD_W    destination register
//  out_valid_o   out  1       head beat valid (registered)
//  out_ready_i   in   1       downstream accepts head
//  regwrite_o    out  1       ctrl[CTRL_W-1] AND out_valid_o
//  memtoreg_o    out  1       ctrl[CTRL_W-2] of head
//  ctrl_o        out  CTRL_W  head control bits
//  memdata_o     out  DATA_W  head memdata
//  aludata_o     out  DATA_W  head aludata
//  rdaddr_o      out  RD_W    head destination
//  wb_data_o     out  DATA_W  memtoreg_o ? memdata_o : aludata_o (combinational from outputs)
//  stall_cnt_o   out  16      saturating count of cycles with in_valid_i & !in_ready_o
// BEHAVIOUR
//  - push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i; both sampled at rising edge.
//  - FSM states EMPTY/ONE/TWO (occupancy), rising edge only:
//    EMPTY: push -> ONE (beat into head).  pop ignored.
//    ONE:   push&!pop -> TWO (beat into skid); pop&!push -> EMPTY; push&pop -> ONE, head <= new beat.
//    TWO:   pop -> ONE, head <= skid; no push possible (in_ready_o=0).
//  - in_ready_o = (next state != TWO); out_valid_o = (state != EMPTY); both registered.
//  - Latency: beat pushed at edge t is on outputs after edge t (HALF_CYCLE=0) or after falling
//    edge t+0.5 (HALF_CYCLE=1). Handshake signals always rising-edge; only payload/ctrl delayed.
//  - Order strictly FIFO; no beat duplicated or lost except by flush/reset.
//  - Payload holds last value when out_valid_o=0; regwrite_o forced 0 so bubbles never write.
//  - flush_i: next state EMPTY, in_ready_o=1, out_valid_o=0; a push in the same cycle is dropped;
//    payload registers hold; stall_cnt_o unaffected.
//  - rst_i (priority over flush): state EMPTY, in_ready_o=1, out_valid_o=0, head/skid/ctrl/payload
//    =0, stall_cnt_o=0. HALF_CYCLE=1: payload outputs reach 0 at the next falling edge.
//    Reset mid-transfer discards all held beats.
//  - stall_cnt_o: +1 per cycle with in_valid_i & !in_ready_o; saturates at 16'hFFFF.
//  - Widths: all data pass-through unmodified; CTRL_W >= 2 required.
// TESTING
//  1 rst_i=1 two cycles -> out_valid_o=0, in_ready_o=1, regwrite_o=0, aludata_o=0, stall_cnt_o=0.
//  2 out_ready_i=1, push aludata 0x10..0x13 back-to-back -> same values out in order, 1-cycle
//    latency, in_ready_o stays 1, stall_cnt_o=0.
//  3 out_ready_i=0, push A,B, hold C valid 3 cycles -> in_ready_o=0 after B, stall_cnt_o=3;
//    then out_ready_i=1 -> A,B,C delivered in order.
//  4 state TWO, flush_i=1 with concurrent in_valid_i (D) -> next cycle out_valid_o=0,
//    regwrite_o=0, in_ready_o=1; D never appears.
//  5 HALF_CYCLE=1, push ctrl=2'b11, memdata=0xDEADBEEF, aludata=0x1234 -> outputs unchanged until
//    falling edge, then wb_data_o=0xDEADBEEF, regwrite_o=1; ctrl=2'b10 -> wb_data_o=0x1234.
//  6 hold in_valid_i=1, out_ready_i=0 for 65540 cycles -> stall_cnt_o=16'hFFFF, no wrap.

Source files
------------

// File: rtl/wb_pipe_stage.sv
// ---------------------------------------------------------------------------
// wb_pipe_stage
// MEM->WB pipeline stage built as a two-entry elastic buffer (head + skid).
// The head entry drives the writeback outputs. The skid entry catches a beat
// that arrives while the head is stalled, so in_ready_o can be a register.
// An optional half-cycle mode re-times the payload onto the falling edge.
// This lets the register file write mid-cycle and be read in the same cycle.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_valid_i/in_ready_o upstream handshake (in_ready_o registered)
//   flush_i               drop every held beat
//   ctrl_i, memdata_i, aludata_i, rdaddr_i   incoming beat
//   out_valid_o/out_ready_i                  downstream handshake
//   regwrite_o, memtoreg_o, ctrl_o, memdata_o, aludata_o, rdaddr_o  head beat
//   wb_data_o             selected writeback value
//   stall_cnt_o           saturating count of upstream stall cycles
// CTRL_W must be at least 2: bit CTRL_W-1 is RegWrite, bit CTRL_W-2 MemToReg.
// ---------------------------------------------------------------------------
module wb_pipe_stage #(
   parameter int DATA_W     = 32,
   parameter int RD_W       = 5,
   parameter int CTRL_W     = 2,
   parameter int HALF_CYCLE = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic              flush_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] memdata_i,
   input  logic [DATA_W-1:0] aludata_i,
   input  logic [RD_W-1:0]   rdaddr_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              regwrite_o,
   output logic              memtoreg_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] memdata_o,
   output logic [DATA_W-1:0] aludata_o,
   output logic [RD_W-1:0]   rdaddr_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic [15:0]       stall_cnt_o
);

   // A beat is packed as {ctrl, memdata, aludata, rdaddr}.
   localparam int BEAT_W = CTRL_W + 2*DATA_W + RD_W;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                r_in_ready;
   logic                r_out_valid;
   logic [BEAT_W-1:0]   r_head;
   logic [BEAT_W-1:0]   r_skid;
   logic [15:0]         r_stall_cnt;
   logic [BEAT_W-1:0]   w_in_beat;
   logic [BEAT_W-1:0]   w_out_beat;
   logic                w_push;
   logic                w_pop;

   assign w_in_beat = {ctrl_i, memdata_i, aludata_i, rdaddr_i};
   assign w_push    = in_valid_i & r_in_ready;
   assign w_pop     = r_out_valid & out_ready_i;

   // Occupancy transition. Flush wins over any handshake in the same cycle.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         EMPTY: if (w_push) w_next_state = ONE;
         ONE: begin
            if (w_push && !w_pop)      w_next_state = TWO;
            else if (w_pop && !w_push) w_next_state = EMPTY;
         end
         TWO:   if (w_pop) w_next_state = ONE;
         default: w_next_state = EMPTY;
      endcase
      if (flush_i) w_next_state = EMPTY;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_head      <= '0;
         r_skid      <= '0;
         r_stall_cnt <= '0;
      end else begin
         // Stall counter keeps counting through flushes and saturates.
         if (in_valid_i && !r_in_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;

         // Flush only clears occupancy. The payload registers keep their value.
         if (!flush_i) begin
            case (r_state)
               EMPTY: if (w_push) r_head <= w_in_beat;
               ONE: begin
                  if (w_push && !w_pop) r_skid <= w_in_beat;
                  if (w_push && w_pop)  r_head <= w_in_beat;
               end
               TWO:   if (w_pop) r_head <= r_skid;
               default: ;
            endcase
         end

         r_state     <= w_next_state;
         r_in_ready  <= (w_next_state != TWO);
         r_out_valid <= (w_next_state != EMPTY);
      end
   end

   // Payload re-timing. In half-cycle mode the head is copied on the falling
   // edge. After reset the zeroed head reaches the outputs half a cycle later.
   generate
      if (HALF_CYCLE != 0) begin : g_half
         logic [BEAT_W-1:0] r_out_neg;
         always_ff @(negedge clk_i) r_out_neg <= r_head;
         assign w_out_beat = r_out_neg;
      end else begin : g_full
         assign w_out_beat = r_head;
      end
   endgenerate

   assign {ctrl_o, memdata_o, aludata_o, rdaddr_o} = w_out_beat;

   assign in_ready_o  = r_in_ready;
   assign out_valid_o = r_out_valid;
   assign stall_cnt_o = r_stall_cnt;
   // Bubbles keep stale control bits, so RegWrite is qualified by valid.
   assign regwrite_o  = ctrl_o[CTRL_W-1] & r_out_valid;
   assign memtoreg_o  = ctrl_o[CTRL_W-2];
   assign wb_data_o   = memtoreg_o ? memdata_o : aludata_o;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_pipe_stage
// Two instances of wb_pipe_stage are driven with identical stimulus:
// dut0 uses HALF_CYCLE=0 and dut1 uses HALF_CYCLE=1.
// Stimulus tasks queue every accepted beat. A monitor pops the queue whenever
// the head is handed over downstream and compares both instances' payloads.
// ---------------------------------------------------------------------------
module tb_wb_pipe_stage;

   typedef struct packed {
      logic [1:0]  c;
      logic [31:0] m;
      logic [31:0] a;
      logic [4:0]  r;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        flush;
   logic        out_ready;
   logic [1:0]  ctrl;
   logic [31:0] memd;
   logic [31:0] alud;
   logic [4:0]  rd;

   logic        in_ready0, out_valid0, regwrite0, memtoreg0;
   logic [1:0]  ctrl0;
   logic [31:0] mem0, alu0, wb0;
   logic [4:0]  rd0;
   logic [15:0] stall0;

   logic        in_ready1, out_valid1, regwrite1, memtoreg1;
   logic [1:0]  ctrl1;
   logic [31:0] mem1, alu1, wb1;
   logic [4:0]  rd1;
   logic [15:0] stall1;

   int    checks = 0;
   int    errors = 0;
   beat_t q[$];

   always #5 clk = ~clk;

   wb_pipe_stage #(.DATA_W(32), .RD_W(5), .CTRL_W(2), .HALF_CYCLE(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready0),
      .flush_i(flush), .ctrl_i(ctrl), .memdata_i(memd), .aludata_i(alud),
      .rdaddr_i(rd), .out_valid_o(out_valid0), .out_ready_i(out_ready),
      .regwrite_o(regwrite0), .memtoreg_o(memtoreg0), .ctrl_o(ctrl0),
      .memdata_o(mem0), .aludata_o(alu0), .rdaddr_o(rd0), .wb_data_o(wb0),
      .stall_cnt_o(stall0));

   wb_pipe_stage #(.DATA_W(32), .RD_W(5), .CTRL_W(2), .HALF_CYCLE(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready1),
      .flush_i(flush), .ctrl_i(ctrl), .memdata_i(memd), .aludata_i(alud),
      .rdaddr_i(rd), .out_valid_o(out_valid1), .out_ready_i(out_ready),
      .regwrite_o(regwrite1), .memtoreg_o(memtoreg1), .ctrl_o(ctrl1),
      .memdata_o(mem1), .aludata_o(alu1), .rdaddr_o(rd1), .wb_data_o(wb1),
      .stall_cnt_o(stall1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a handover happens at the coming rising edge.
   always @(negedge clk) begin
      #1;
      if (!rst && out_valid0 && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got alu 0x%0h, expected no beat", alu0);
         end else begin
            beat_t e;
            e = q.pop_front();
            chk("mon_ctrl0", 64'(ctrl0), 64'(e.c));
            chk("mon_mem0",  64'(mem0),  64'(e.m));
            chk("mon_alu0",  64'(alu0),  64'(e.a));
            chk("mon_rd0",   64'(rd0),   64'(e.r));
            chk("mon_wb0",   64'(wb0),   64'(e.c[0] ? e.m : e.a));
            chk("mon_rw0",   64'(regwrite0), 64'(e.c[1]));
            chk("mon_alu1",  64'(alu1),  64'(e.a));
            chk("mon_wb1",   64'(wb1),   64'(e.c[0] ? e.m : e.a));
            chk("mon_rd1",   64'(rd1),   64'(e.r));
         end
      end
   end

   // Offer one beat and wait, with a bound, until it is accepted.
   task automatic send(input logic [1:0] c, input logic [31:0] m, input logic [31:0] a,
                       input logic [4:0] r);
      int n;
      n = 0;
      in_valid = 1'b1; ctrl = c; memd = m; alud = a; rd = r;
      forever begin
         @(negedge clk); #1;
         if (in_ready0) break;
         n++;
         if (n > 100) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready 0, expected 1");
            break;
         end
      end
      if (in_ready0) q.push_back(beat_t'{c, m, a, r});
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   logic [31:0] prev;

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      ctrl = '0; memd = '0; alud = '0; rd = '0;

      // 1: reset
      @(posedge clk); @(posedge clk); #1;
      chk("rst_out_valid", 64'(out_valid0), 64'd0);
      chk("rst_in_ready",  64'(in_ready0),  64'd1);
      chk("rst_regwrite",  64'(regwrite0),  64'd0);
      chk("rst_aludata",   64'(alu0),       64'd0);
      chk("rst_stall",     64'(stall0),     64'd0);
      @(negedge clk); #1;
      chk("rst_aludata_hc", 64'(alu1), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 2: back-to-back stream with downstream always ready
      out_ready = 1'b1;
      send(2'b10, 32'hA0, 32'h10, 5'd1);
      chk("lat_valid", 64'(out_valid0), 64'd1);
      chk("lat_alu",   64'(alu0),       64'h10);
      for (int i = 1; i < 4; i++) begin
         send(2'b10, 32'hA0 + 32'(i), 32'h10 + 32'(i), 5'(i + 1));
         chk("stream_in_ready", 64'(in_ready0), 64'd1);
      end
      drain();
      chk("stream_stall", 64'(stall0), 64'd0);

      // 3: fill both entries, stall C for three cycles, then release
      out_ready = 1'b0;
      send(2'b11, 32'h1111, 32'hAAAA, 5'd3);
      send(2'b10, 32'h2222, 32'hBBBB, 5'd4);
      in_valid = 1'b1; ctrl = 2'b01; memd = 32'h3333; alud = 32'hCCCC; rd = 5'd5;
      repeat (3) @(posedge clk);
      #1;
      chk("full_in_ready", 64'(in_ready0), 64'd0);
      chk("full_stall",    64'(stall0),    64'd3);
      out_ready = 1'b1;
      send(2'b01, 32'h3333, 32'hCCCC, 5'd5);
      drain();

      // 4: flush while full with a concurrent push of D
      out_ready = 1'b0;
      send(2'b11, 32'h4444, 32'hE0E0, 5'd6);
      send(2'b11, 32'h5555, 32'hF0F0, 5'd7);
      in_valid = 1'b1; flush = 1'b1;
      ctrl = 2'b11; memd = 32'hDDDD; alud = 32'hD0D0; rd = 5'd8;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      q.delete();
      chk("flush_out_valid", 64'(out_valid0), 64'd0);
      chk("flush_regwrite",  64'(regwrite0),  64'd0);
      chk("flush_in_ready",  64'(in_ready0),  64'd1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("flush_stays_empty", 64'(out_valid0), 64'd0);
      send(2'b01, 32'h55, 32'h66, 5'd9);
      drain();

      // 5: half-cycle payload timing
      prev = wb1;
      in_valid = 1'b1; ctrl = 2'b11; memd = 32'hDEADBEEF; alud = 32'h1234; rd = 5'd10;
      chk("hc_in_ready", 64'(in_ready1), 64'd1);
      q.push_back(beat_t'{2'b11, 32'hDEADBEEF, 32'h1234, 5'd10});
      @(posedge clk); #1;
      chk("hc_hold1", 64'(wb1), 64'(prev));
      chk("hc_valid", 64'(out_valid1), 64'd1);
      ctrl = 2'b10; rd = 5'd11;
      q.push_back(beat_t'{2'b10, 32'hDEADBEEF, 32'h1234, 5'd11});
      @(negedge clk); #1;
      chk("hc_wb_mem",   64'(wb1),       64'hDEADBEEF);
      chk("hc_regwrite", 64'(regwrite1), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hc_hold2", 64'(wb1), 64'hDEADBEEF);
      @(negedge clk); #1;
      chk("hc_wb_alu", 64'(wb1), 64'h1234);
      drain();

      // 6: stall counter saturation
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0; q.delete();
      out_ready = 1'b0; in_valid = 1'b1;
      ctrl = 2'b10; memd = 32'h7; alud = 32'h8; rd = 5'd12;
      repeat (65540) @(posedge clk);
      #1;
      chk("sat_stall0", 64'(stall0), 64'hFFFF);
      chk("sat_stall1", 64'(stall1), 64'hFFFF);
      repeat (5) @(posedge clk);
      #1;
      chk("sat_no_wrap", 64'(stall0), 64'hFFFF);
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      q.delete();
      chk("sat_reset", 64'(stall0), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
